// File: rtl/tick_countdown_timer.sv
// Countdown timer advanced by edge-qualified ticks from a slow timebase.
// Optional build macro AUTO_RELOAD_EN: the terminal tick reloads load_val and keeps running.
module tick_countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_expired;
  logic             r_tick_d;

  logic             w_tq;
  logic             w_load_zero;

  // A tick held high for several cycles must count only once.
  assign w_tq        = tick & ~r_tick_d;
  assign w_load_zero = (load_val == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
      r_tick_d  <= 1'b0;
    end else begin
      r_tick_d  <= tick;
      r_expired <= 1'b0;
      if (start) begin
        r_count <= load_val;
        if (w_load_zero) begin
          r_state   <= DONE;
          r_expired <= 1'b1;
        end else begin
          r_state <= RUN;
        end
      end else begin
        case (r_state)
          RUN: begin
            if (pause) begin
              r_state <= PAUSED;
            end else if (w_tq) begin
              if (r_count > WIDTH'(1)) begin
                r_count <= r_count - WIDTH'(1);
              end else begin
                r_expired <= 1'b1;
`ifdef AUTO_RELOAD_EN
                if (!w_load_zero) begin
                  r_count <= load_val;
                end else begin
                  r_count <= '0;
                  r_state <= DONE;
                end
`else
                r_count <= '0;
                r_state <= DONE;
`endif
              end
            end
          end
          // Leaving pause swallows any tick on the same edge.
          PAUSED: begin
            if (!pause) r_state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign count   = r_count;
  assign expired = r_expired;
  assign state   = r_state;
  assign busy    = (r_state == RUN) || (r_state == PAUSED);

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer: per-cycle model comparison plus literal checkpoints.
module tb_tick_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic       pause;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy;
  logic       expired;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_cmp = 1'b0;

  // Model state: mode 0 idle, 1 run, 2 paused, 3 done.
  int m_cnt;
  int m_mode;
  bit m_exp;
  bit m_tick_prev;
  bit prev_exp;

  tick_countdown_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .pause    (pause),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .expired  (expired),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp_v, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt       <= 0;
      m_mode      <= 0;
      m_exp       <= 1'b0;
      m_tick_prev <= 1'b0;
    end else begin
      int c;
      int md;
      bit e;
      bit fresh;
      fresh = tick && !m_tick_prev;
      c  = m_cnt;
      md = m_mode;
      e  = 1'b0;
      if (start) begin
        c  = int'(load_val);
        md = (load_val == 0) ? 3 : 1;
        e  = (load_val == 0);
      end else if (md == 1 && pause) begin
        md = 2;
      end else if (md == 2) begin
        if (!pause) md = 1;
      end else if (md == 1 && fresh) begin
        c = c - 1;
        if (c == 0) begin
          e = 1'b1;
`ifdef AUTO_RELOAD_EN
          if (load_val != 0) c = int'(load_val);
          else md = 3;
`else
          md = 3;
`endif
        end
      end
      m_cnt       <= c;
      m_mode      <= md;
      m_exp       <= e;
      m_tick_prev <= tick;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_count", int'(count), m_cnt);
      check("cmp_state", int'(state), m_mode);
      check("cmp_busy", int'(busy), (m_mode == 1 || m_mode == 2) ? 1 : 0);
      check("cmp_expired", int'(expired), int'(m_exp));
      check("exp_double", int'(expired && prev_exp), 0);
    end
    prev_exp <= expired;
  end

  task automatic step(input logic s, input logic p, input logic t, input logic [7:0] lv);
    start    = s;
    pause    = p;
    tick     = t;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
    prev_exp = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    run_cmp = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_expired", int'(expired), 0);

    step(0, 1, 1, 8'd0); step(0, 0, 0, 8'd0);
    check("idle_ignore", int'(state), 0);

    step(1, 0, 0, 8'd3);
    check("l3_count", int'(count), 3);
    check("l3_busy", int'(busy), 1);
    step(0, 0, 1, 8'd3); check("l3_t1", int'(count), 2);
    step(0, 0, 0, 8'd3);
    step(0, 0, 1, 8'd3); check("l3_t2", int'(count), 1);
    step(0, 0, 0, 8'd3);
    step(0, 0, 1, 8'd3);
    check("l3_t3", int'(count), 0);
    check("l3_exp", int'(expired), 1);
    check("l3_done", int'(state), 3);
    check("l3_busy0", int'(busy), 0);
    step(0, 0, 0, 8'd3); check("l3_exp_off", int'(expired), 0);
    step(0, 0, 1, 8'd3); step(0, 0, 0, 8'd3);
    check("done_hold", int'(count), 0);

    step(1, 0, 0, 8'd5);
    repeat (4) step(0, 0, 1, 8'd5);
    check("held_tick", int'(count), 4);
    step(0, 0, 0, 8'd5);

    step(0, 1, 0, 8'd5); check("pause_st", int'(state), 2);
    step(0, 1, 1, 8'd5); step(0, 1, 0, 8'd5); step(0, 1, 1, 8'd5);
    check("pause_hold", int'(count), 4);
    step(0, 0, 0, 8'd5); check("resume_st", int'(state), 1);
    step(0, 0, 1, 8'd5); check("resume_tick", int'(count), 3);
    step(0, 0, 0, 8'd5);

    step(0, 1, 0, 8'd5);
    step(0, 0, 1, 8'd5); check("resume_swallow", int'(count), 3);
    step(0, 0, 0, 8'd5);

    step(0, 0, 1, 8'd5); check("pre_restart", int'(count), 2);
    step(0, 0, 0, 8'd5);
    step(1, 0, 1, 8'd7);
    check("restart_cnt", int'(count), 7);
    check("restart_st", int'(state), 1);
    step(0, 0, 0, 8'd7);

    step(1, 1, 0, 8'd4); check("sp_run", int'(state), 1);
    step(0, 1, 0, 8'd4); check("sp_pause", int'(state), 2);
    step(0, 0, 0, 8'd4);

    step(1, 0, 0, 8'd0);
    check("z_state", int'(state), 3);
    check("z_exp", int'(expired), 1);
    step(0, 0, 0, 8'd0);

    step(1, 0, 0, 8'd255); check("max_load", int'(count), 255);
    step(0, 0, 1, 8'd255); check("max_dec", int'(count), 254);
    step(0, 0, 0, 8'd255);

    step(1, 0, 0, 8'd2); check("pre_rst_cnt", int'(count), 2);
    start = 1'b0; load_val = '0;
    #2 reset = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_count", int'(count), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_exp", int'(expired), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) step(0, 0, 0, 8'd0);

`ifdef AUTO_RELOAD_EN
    step(1, 0, 0, 8'd2); check("ar_c0", int'(count), 2);
    step(0, 0, 1, 8'd2); check("ar_c1", int'(count), 1);
    step(0, 0, 0, 8'd2);
    step(0, 0, 1, 8'd2);
    check("ar_c2", int'(count), 2);
    check("ar_e2", int'(expired), 1);
    check("ar_s2", int'(state), 1);
    step(0, 0, 0, 8'd2);
    step(0, 0, 1, 8'd2); check("ar_c3", int'(count), 1);
    step(0, 0, 0, 8'd2);
    step(0, 0, 1, 8'd2);
    check("ar_c4", int'(count), 2);
    check("ar_e4", int'(expired), 1);
    step(0, 0, 0, 8'd2);
    step(1, 0, 0, 8'd0);
    check("ar_done", int'(state), 3);
    check("ar_zexp", int'(expired), 1);
    step(0, 0, 0, 8'd0);
`endif

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tick_countdown_timer.md
TICK_COUNTDOWN_TIMER -- requirements
Module: tick_countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port tick, input, 1, timebase strobe from the 1 Hz divider; one event per rising edge.
REQ-005 The block SHALL have port start, input, 1, loads load_val and begins counting.
REQ-006 The block SHALL have port pause, input, 1, level; while high, counting is suspended.
REQ-007 The block SHALL have port load_val, input, WIDTH, initial count sampled on start.
REQ-008 The block SHALL have port count, output, WIDTH, current remaining count.
REQ-009 The block SHALL have port busy, output, 1, high in RUN or PAUSED.
REQ-010 The block SHALL have port expired, output, 1, single-cycle pulse on reaching zero.
REQ-011 The block SHALL have port state, output, 2, encoding IDLE=0, RUN=1, PAUSED=2, DONE=3.

Function
REQ-012 The block SHALL register tick into tick_d and SHALL define qualified tick tq = tick & ~tick_d, so a tick held high N cycles counts once.
REQ-013 In IDLE or DONE, start=1 with load_val!=0 SHALL set count<=load_val and state<=RUN at the same edge.
REQ-014 start=1 with load_val==0, in any state, SHALL set count<=0, state<=DONE and pulse expired in the following cycle.
REQ-015 In RUN, tq with count>1 SHALL decrement count by 1.
REQ-016 In RUN, tq with count==1 SHALL set count<=0, state<=DONE and expired<=1 for exactly one cycle.
REQ-017 In RUN, pause=1 without start SHALL move to PAUSED; count SHALL hold and tq SHALL be ignored.
REQ-018 In PAUSED, pause=0 SHALL return to RUN; a tq on that same edge SHALL be ignored.
REQ-019 start in RUN or PAUSED SHALL restart: count<=load_val, state<=RUN.
REQ-020 Priority SHALL be start > pause > tq; start with pause both high enters RUN, and pause takes effect the next cycle.
REQ-021 DONE SHALL hold count=0 until start; tq and pause SHALL have no effect in IDLE or DONE.
REQ-022 Decrement SHALL never wrap below 0; count SHALL stay within WIDTH bits.
REQ-023 expired SHALL be registered (high the cycle after the terminal edge) and SHALL never be high two consecutive cycles without a new terminal event.
REQ-024 busy SHALL be decoded from the state register (RUN or PAUSED).

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, count=0, expired=0, busy=0, tick_d=0.
REQ-026 reset during RUN or PAUSED SHALL abort the count with no expired pulse.
REQ-027 After reset deasserts, a tick already high SHALL produce one tq on the first edge.

Configuration
REQ-028 Macro AUTO_RELOAD_EN SHALL, when defined, make the RUN terminal tq (count==1) pulse expired, reload count<=load_val and remain in RUN; if load_val==0 at that edge, the block SHALL go to DONE instead.
REQ-029 Without AUTO_RELOAD_EN, the terminal tq SHALL always go to DONE as in REQ-016.

Verification
REQ-030 Load 3 and start, then 3 single-cycle ticks -> count 3,2,1,0; expired one cycle after third tick; state DONE; busy low.
REQ-031 Load 5 and run; tick held high 4 cycles -> count decrements once, to 4.
REQ-032 Count 4 in RUN; pause=1 across 2 ticks; pause=0; 1 tick -> count 4,4,3; state 1->2->1.
REQ-033 Count 2 in RUN; start with load_val=7 and tick on the same edge -> count=7, no decrement, state RUN.
REQ-034 Count 2 in RUN; assert reset asynchronously mid-cycle -> state IDLE, count 0 immediately, no expired pulse.
REQ-035 With AUTO_RELOAD_EN and load 2, 4 ticks -> expired after ticks 2 and 4; count 2,1,2,1,2; state stays RUN; start with load_val=0 -> DONE plus expired.
